mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the 16-bit pipelined processor. It consumes the EX/MEM register (PC, write data, imm8, rs, destination register, ALU result, control bits) and runs the data-memory request/acknowledge handshake.
- Resolves branches and produces the MEM-stage forwarding value (WBResultM) back to EX.
- Drives the MEM/WB pipeline register and requests a pipeline stall while a memory access is outstanding.

Parameters:
- DATA_WIDTH, 16, datapath width
- ADDR_WIDTH, 8, instruction and data address width
- REG_WIDTH, 4, register index width
- ACK_TIMEOUT, 15, maximum WAIT cycles before abort (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- PCM_i  in  ADDR_WIDTH  PC of the instruction in MEM
- WriteDataM_i  in  DATA_WIDTH  store data
- imm8M_i  in  DATA_WIDTH  immediate; low 8 bits significant
- WriteRegM_i  in  REG_WIDTH  destination register
- alu_outM_i  in  DATA_WIDTH  ALU result / memory address
- RegWriteM_i, BranchM_i, MemReadM_i, MemWriteM_i, MemToRegM_i, MovM_i  in  1 each  control bits
- flush_MEM_WB_i  in  1  load a bubble into MEM/WB
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_WIDTH  alu_outM_i[ADDR_WIDTH-1:0]
- dmem_wdata_o  out  DATA_WIDTH  WriteDataM_i
- dmem_rdata_i  in  DATA_WIDTH  read data, valid with ack
- dmem_ack_i  in  1  access complete
- WBResultM_o  out  DATA_WIDTH  forwarding value to EX
- PCSrcM_o  out  1  branch taken
- BranchTargetM_o  out  ADDR_WIDTH  branch target
- stall_mem_o  out  1  hold IF..EX/MEM
- mem_err_o  out  1  sticky timeout flag
- ReadDataW_o, alu_outW_o  out  DATA_WIDTH  MEM/WB data
- WriteRegW_o  out  REG_WIDTH  MEM/WB destination register
- RegWriteW_o, MemToRegW_o  out  1  MEM/WB control bits

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, the timeout counter clears, and every registered output clears to 0, including mem_err_o. dmem_req_o drops immediately, including mid-access.
- Combinational outputs:
  - WBResultM_o = MovM_i ? imm8M_i : alu_outM_i.
  - PCSrcM_o = BranchM_i & (alu_outM_i == 0).
  - BranchTargetM_o = PCM_i + sign-extended imm8M_i[7:0], modulo 2^ADDR_WIDTH (wraps).
- mem_op = MemReadM_i | MemWriteM_i. dmem_we_o = MemWriteM_i; when read and write are both set, the access is a write.
- FSM states IDLE and WAIT:
  - IDLE, no mem_op: no request. MEM/WB loads the instruction normally in the next clock.
  - IDLE, mem_op: dmem_req_o=1 combinationally.
    - ack the same cycle (zero-wait): stall_mem_o=0, MEM/WB captures dmem_rdata_i, stay in IDLE.
    - no ack: stall_mem_o=1, go to WAIT, counter=1.
  - WAIT: dmem_req_o=1; dmem_addr_o, dmem_wdata_o and dmem_we_o stay stable because EX/MEM is stalled.
    - ack: stall_mem_o=0, MEM/WB captures the result, go to IDLE.
    - no ack, counter < ACK_TIMEOUT: stall_mem_o=1, counter increments.
    - no ack, counter == ACK_TIMEOUT: abort. mem_err_o is set and sticky until reset, stall_mem_o=0, MEM/WB loads a bubble, go to IDLE.
- MEM/WB register:
  - Normal load: ReadDataW_o=dmem_rdata_i (reads only, else held), alu_outW_o=WBResultM_o, WriteRegW_o, RegWriteW_o, MemToRegW_o.
  - While stall_mem_o=1, on abort, or on flush_MEM_WB_i: a bubble loads, with all MEM/WB outputs 0.
  - flush_MEM_WB_i has priority over a normal load. It does not cancel an outstanding access; the FSM continues.
- An ack received in IDLE without a request is ignored.
- Latency: a zero-wait access adds 0 stall cycles; N wait cycles produce N stall cycles.

Decomposition:
- Shared package pipe_pkg holds the FSM state enum (IDLE, WAIT), the DATA/ADDR/REG width constants, and the imm8 sign-extension function.
- One sub-module, mem_wb_reg, implements the MEM/WB register with flush and bubble control. The FSM and branch logic stay in mem_stage.

Test Plan:
1. Load, zero-wait: MemReadM=1, alu_out=0x0012, ack in the same cycle with rdata=0xBEEF -> no stall; next cycle ReadDataW=0xBEEF, MemToRegW=1.
2. Store, 3 wait cycles: MemWriteM=1, WriteData=0x1234, ack on the 4th cycle -> dmem_we=1 with addr/wdata stable throughout; stall_mem_o=1 for 3 cycles with RegWriteW=0 bubbles; stall drops on the ack cycle.
3. Branch: BranchM=1, alu_out=0, PCM=0xFE, imm8=0x05 -> PCSrcM=1, target=0x03 (wrap). Same with imm8=0xFC -> target=0xFA.
4. Timeout: MemReadM=1, ack never asserted, ACK_TIMEOUT=15 -> 15 stall cycles, then mem_err_o=1 (sticky), stall drops, MEM/WB holds a bubble.
5. Reset in WAIT: drive rst=0 on the 2nd wait cycle -> dmem_req_o and all outputs are 0 immediately; after release, the FSM is in IDLE.
6. Mov forwarding and flush: MovM=1, imm8=0x0077, flush_MEM_WB_i=1 -> WBResultM=0x0077 the same cycle; next cycle RegWriteW=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline: default widths, MEM-stage FSM states
// and the imm8 sign-extension helper.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] sext_imm8(input logic [7:0] imm);
    return {{(DATA_W-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble zeroes every field; otherwise read data
// is captured only for loads and held for everything else.
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int REG_WIDTH  = REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble_i,
  input  logic                  load_rdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [DATA_WIDTH-1:0] alu_i,
  input  logic [REG_WIDTH-1:0]  wreg_i,
  input  logic                  regwrite_i,
  input  logic                  memtoreg_i,
  output logic [DATA_WIDTH-1:0] ReadDataW_o,
  output logic [DATA_WIDTH-1:0] alu_outW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  MemToRegW_o
);

  logic [DATA_WIDTH-1:0] rdata_q, alu_q;
  logic [REG_WIDTH-1:0]  wreg_q;
  logic                  regwrite_q, memtoreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q    <= '0;
      alu_q      <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (bubble_i) begin
      rdata_q    <= '0;
      alu_q      <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      if (load_rdata_i) rdata_q <= rdata_i;
      alu_q      <= alu_i;
      wreg_q     <= wreg_i;
      regwrite_q <= regwrite_i;
      memtoreg_q <= memtoreg_i;
    end
  end

  assign ReadDataW_o = rdata_q;
  assign alu_outW_o  = alu_q;
  assign WriteRegW_o = wreg_q;
  assign RegWriteW_o = regwrite_q;
  assign MemToRegW_o = memtoreg_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack handshake with timeout abort,
// branch resolution, MEM-stage forwarding value and the MEM/WB register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int REG_WIDTH   = REG_W,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [DATA_WIDTH-1:0] imm8M_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  flush_MEM_WB_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic                  PCSrcM_o,
  output logic [ADDR_WIDTH-1:0] BranchTargetM_o,
  output logic                  stall_mem_o,
  output logic                  mem_err_o,
  output logic [DATA_WIDTH-1:0] ReadDataW_o,
  output logic [DATA_WIDTH-1:0] alu_outW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  MemToRegW_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            req_c, stall_c, abort_c, mem_op;
  logic [DATA_W-1:0] imm_sext;

  assign mem_op          = MemReadM_i | MemWriteM_i;
  assign imm_sext        = sext_imm8(imm8M_i[7:0]);
  assign WBResultM_o     = MovM_i ? imm8M_i : alu_outM_i;
  assign PCSrcM_o        = BranchM_i & (alu_outM_i == '0);
  assign BranchTargetM_o = PCM_i + imm_sext[ADDR_WIDTH-1:0];

  assign dmem_we_o    = MemWriteM_i;
  assign dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
  assign dmem_wdata_o = WriteDataM_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_c = 1'b1;
          if (!dmem_ack_i) begin
            stall_c = 1'b1;
            state_d = WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (dmem_ack_i) begin
          state_d = IDLE;
        end else if (cnt_q < TIMEOUT_C) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          abort_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_q | abort_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset must kill the request at once even if EX/MEM still holds a mem op.
  assign dmem_req_o  = rst & req_c;
  assign stall_mem_o = rst & stall_c;
  assign mem_err_o   = err_q;

  mem_wb_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .bubble_i    (stall_c | abort_c | flush_MEM_WB_i),
    .load_rdata_i(MemReadM_i & ~MemWriteM_i),
    .rdata_i     (dmem_rdata_i),
    .alu_i       (WBResultM_o),
    .wreg_i      (WriteRegM_i),
    .regwrite_i  (RegWriteM_i),
    .memtoreg_i  (MemToRegM_i),
    .ReadDataW_o (ReadDataW_o),
    .alu_outW_o  (alu_outW_o),
    .WriteRegW_o (WriteRegW_o),
    .RegWriteW_o (RegWriteW_o),
    .MemToRegW_o (MemToRegW_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expected MEM/WB contents are queued when each
// instruction is driven and compared after the clock edge that loads them.
module tb_mem_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCM;
  logic [15:0] WriteDataM, imm8M, alu_outM, dmem_rdata;
  logic [3:0]  WriteRegM;
  logic        RegWriteM, BranchM, MemReadM, MemWriteM, MemToRegM, MovM, flush;
  logic        dmem_ack;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, BranchTarget;
  logic [15:0] dmem_wdata, WBResultM, ReadDataW, alu_outW;
  logic        PCSrcM, stall, mem_err, RegWriteW, MemToRegW;
  logic [3:0]  WriteRegW;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .PCM_i(PCM), .WriteDataM_i(WriteDataM), .imm8M_i(imm8M),
    .WriteRegM_i(WriteRegM), .alu_outM_i(alu_outM), .RegWriteM_i(RegWriteM),
    .BranchM_i(BranchM), .MemReadM_i(MemReadM), .MemWriteM_i(MemWriteM),
    .MemToRegM_i(MemToRegM), .MovM_i(MovM), .flush_MEM_WB_i(flush),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
    .WBResultM_o(WBResultM), .PCSrcM_o(PCSrcM), .BranchTargetM_o(BranchTarget),
    .stall_mem_o(stall), .mem_err_o(mem_err), .ReadDataW_o(ReadDataW),
    .alu_outW_o(alu_outW), .WriteRegW_o(WriteRegW), .RegWriteW_o(RegWriteW),
    .MemToRegW_o(MemToRegW)
  );

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] alu;
    logic [3:0]  wr;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t         sb_q[$];
  logic [15:0] exp_rd;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_bubble();
    exp_rd = '0;
    sb_q.push_back('0);
  endtask

  task automatic exp_load(input logic rd_valid, input logic [15:0] rd, input logic [15:0] alu,
                          input logic [3:0] wr, input logic rw, input logic m2r);
    wb_t e;
    if (rd_valid) exp_rd = rd;
    e.rd = exp_rd; e.alu = alu; e.wr = wr; e.rw = rw; e.m2r = m2r;
    sb_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    wb_t e, o;
    @(posedge clk);
    #1;
    o = {ReadDataW, alu_outW, WriteRegW, RegWriteW, MemToRegW};
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_memwb"}, 64'(o), 64'(e));
    end
    $display("[%0t] %s memwb rd=%h alu=%h wr=%0d rw=%b m2r=%b stall=%b err=%b",
             $time, tag, ReadDataW, alu_outW, WriteRegW, RegWriteW, MemToRegW, stall, mem_err);
  endtask

  task automatic idle_inputs();
    PCM = '0; WriteDataM = '0; imm8M = '0; alu_outM = '0; dmem_rdata = '0;
    WriteRegM = '0; RegWriteM = 0; BranchM = 0; MemReadM = 0; MemWriteM = 0;
    MemToRegM = 0; MovM = 0; flush = 0; dmem_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    exp_rd = '0;
    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_memwb", {ReadDataW, alu_outW, WriteRegW, RegWriteW, MemToRegW}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: zero-wait load
    MemReadM = 1; alu_outM = 16'h0012; WriteRegM = 4'd3; RegWriteM = 1; MemToRegM = 1;
    dmem_ack = 1; dmem_rdata = 16'hBEEF;
    #1;
    chk("t1_req", dmem_req, 1);
    chk("t1_stall", stall, 0);
    chk("t1_we", dmem_we, 0);
    chk("t1_addr", dmem_addr, 8'h12);
    exp_load(1, 16'hBEEF, 16'h0012, 4'd3, 1, 1);
    tick("t1_load");
    idle_inputs();

    // 2: store with three wait cycles
    MemWriteM = 1; WriteDataM = 16'h1234; alu_outM = 16'h0040; WriteRegM = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req", dmem_req, 1);
      chk("t2_we", dmem_we, 1);
      chk("t2_addr", dmem_addr, 8'h40);
      chk("t2_wdata", dmem_wdata, 16'h1234);
      chk("t2_stall", stall, 1);
      exp_bubble();
      tick("t2_wait");
    end
    dmem_ack = 1;
    #1;
    chk("t2_ack_stall", stall, 0);
    chk("t2_ack_req", dmem_req, 1);
    exp_load(0, 16'h0, 16'h0040, 4'd2, 0, 0);
    tick("t2_done");
    idle_inputs();

    // stray ack in IDLE is ignored
    dmem_ack = 1; alu_outM = 16'h0055; RegWriteM = 1; WriteRegM = 4'd7;
    #1;
    chk("ign_req", dmem_req, 0);
    chk("ign_stall", stall, 0);
    exp_load(0, 16'h0, 16'h0055, 4'd7, 1, 0);
    tick("ign_ack");
    idle_inputs();

    // 3: branch resolution with wrapping target
    BranchM = 1; alu_outM = 16'h0000; PCM = 8'hFE; imm8M = 16'h0005;
    #1;
    chk("t3_pcsrc", PCSrcM, 1);
    chk("t3_tgt_fwd", BranchTarget, 8'h03);
    imm8M = 16'h00FC;
    #1;
    chk("t3_tgt_back", BranchTarget, 8'hFA);
    alu_outM = 16'h0001;
    #1;
    chk("t3_not_taken", PCSrcM, 0);
    idle_inputs();

    // 4: load never acknowledged -> timeout abort
    MemReadM = 1; alu_outM = 16'h0020; RegWriteM = 1; WriteRegM = 4'd4; MemToRegM = 1;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("t4_stall", stall, 1);
      exp_bubble();
      tick("t4_wait");
    end
    #1;
    chk("t4_abort_stall", stall, 0);
    chk("t4_abort_req", dmem_req, 1);
    chk("t4_err_before", mem_err, 0);
    exp_bubble();
    tick("t4_abort");
    idle_inputs();
    #1;
    chk("t4_err", mem_err, 1);
    chk("t4_stall_after", stall, 0);
    exp_load(0, 16'h0, 16'h0, 4'd0, 0, 0);
    tick("t4_next");
    chk("t4_err_sticky", mem_err, 1);

    // 5: asynchronous reset during the second wait cycle
    MemReadM = 1; alu_outM = 16'h0030; RegWriteM = 1; WriteRegM = 4'd6;
    #1;
    chk("t5_stall", stall, 1);
    exp_bubble();
    tick("t5_idle");
    exp_bubble();
    tick("t5_wait1");
    chk("t5_wait2_stall", stall, 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_req", dmem_req, 0);
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_err", mem_err, 0);
    chk("t5_rst_memwb", {ReadDataW, alu_outW, WriteRegW, RegWriteW, MemToRegW}, 0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    exp_rd = '0;
    #1;
    chk("t5_rel_req", dmem_req, 0);
    chk("t5_rel_stall", stall, 0);
    MemReadM = 1; alu_outM = 16'h0030; RegWriteM = 1; WriteRegM = 4'd6; MemToRegM = 1;
    dmem_ack = 1; dmem_rdata = 16'hCAFE;
    #1;
    chk("t5_idle_zw_stall", stall, 0);
    exp_load(1, 16'hCAFE, 16'h0030, 4'd6, 1, 1);
    tick("t5_load");
    idle_inputs();

    // 6: Mov forwarding and MEM/WB flush
    MovM = 1; imm8M = 16'h0077; alu_outM = 16'h0999; RegWriteM = 1; WriteRegM = 4'd5; flush = 1;
    #1;
    chk("t6_fwd", WBResultM, 16'h0077);
    exp_bubble();
    tick("t6_flush");
    flush = 0;
    #1;
    chk("t6_fwd2", WBResultM, 16'h0077);
    exp_load(0, 16'h0, 16'h0077, 4'd5, 1, 0);
    tick("t6_load");
    MovM = 0;
    #1;
    chk("t6_alu_fwd", WBResultM, 16'h0999);
    idle_inputs();

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
